gbe_rx_app_ctrl: RTL and testbench
==================================

GBE_RX_APP_CTRL -- requirements
Module: gbe_rx_app_ctrl

Interface
REQ-001 Parameters SHALL be:
- MAX_LEN, default 1472, maximum payload bytes per packet (1..2047).
- OVR_RST_CYCLES, default 4, number of cycles rx_rst is held high during recovery (1..15).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- app_clk  in  1  sole clock.
- app_rst_n  in  1  reset, asynchronous assert, active-low.
- rx_data  in  8  payload byte from the gbe_rx application side.
- rx_dvld  in  1  rx_data valid (upstream FIFO not empty).
- rx_eof  in  1  current byte is the last byte of its packet.
- rx_badframe  in  1  current packet flagged bad.
- rx_srcip  in  32  source IP of the head packet.
- rx_srcport  in  16  source UDP port of the head packet.
- rx_overrun  in  1  upstream overrun flag.
- rx_ack  out  1  pop one byte from upstream.
- rx_rst  out  1  upstream FIFO/overrun clear, active-high.
- m_data  out  8  downstream byte.
- m_valid  out  1  downstream beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_sof  out  1  first beat of a packet.
- m_eof  out  1  last beat of a packet.
- m_err  out  1  packet errored or truncated; valid only with m_eof.
- m_srcip  out  32  source IP, held for the whole packet.
- m_srcport  out  16  source port, held for the whole packet.
- enable  in  1  accept new packets.
- busy  out  1  state is not IDLE.
- pkt_count  out  32  packets delivered with m_err=0; wraps.
- drop_count  out  16  packets dropped; saturates at 0xFFFF.
- ovr_count  out  16  overrun recoveries; saturates at 0xFFFF.

REQ-003 Clock and reset SHALL be one clock, app_clk, and reset app_rst_n, which is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have the states IDLE, DATA, TERM, DROP and RECOVER; the checks in each state are evaluated in the order listed.

REQ-005 IDLE:
- rx_overrun=1 -> RECOVER.
- else rx_dvld=1 and enable=1 -> DATA; m_srcip/m_srcport are captured from rx_srcip/rx_srcport in the same cycle, the length counter is cleared, and the sof flag is set.
- else rx_dvld=1 and enable=0 -> DROP.
- rx_ack=0 throughout IDLE.

REQ-006 DATA, pop rule: rx_ack = rx_dvld & !rx_overrun & (!m_valid | m_ready). The popped byte is registered into m_data/m_valid in the next cycle, so latency is 1 cycle.

REQ-007 DATA, flags on the popped beat:
- m_sof = 1 on the first popped beat only.
- m_eof = rx_eof.
- m_err = rx_eof & rx_badframe.
- The 11-bit length counter increments per pop.

REQ-008 DATA, last beat: popping a beat with rx_eof=1 -> IDLE. pkt_count increments if m_err=0; otherwise drop_count increments.

REQ-009 DATA, overlength: popping the MAX_LEN-th byte with rx_eof=0 SHALL emit that beat with m_eof=1 and m_err=1, increment drop_count, and go to DROP.

REQ-010 DATA, overrun: rx_overrun=1 -> TERM.

REQ-011 TERM:
- When !m_valid | m_ready, load the terminator beat: m_data=0x00, m_eof=1, m_err=1, m_sof=0.
- Increment drop_count, then go to RECOVER.
- rx_ack=0 throughout TERM.

REQ-012 DROP:
- rx_ack = rx_dvld.
- Popping a beat with rx_eof=1 -> IDLE; drop_count increments only if the drop was entered from IDLE.
- rx_overrun=1 -> RECOVER.
- m_valid is unaffected.

REQ-013 RECOVER:
- On entry, ovr_count increments.
- rx_rst = 1 for exactly OVR_RST_CYCLES cycles.
- Then wait with rx_rst=0 until rx_overrun=0 and m_valid=0 -> IDLE.
- rx_ack=0 throughout RECOVER.

REQ-014 m_valid SHALL stay high, with m_data, m_sof, m_eof and m_err stable, until m_ready=1. m_valid clears on m_ready unless a new beat loads in the same cycle.

REQ-015 A new packet's m_srcip/m_srcport SHALL NOT change while m_valid=1 for a beat of the previous packet; IDLE leaves only once m_valid=0 or m_ready=1.

REQ-016 enable SHALL be sampled in IDLE only; deasserting it mid-packet does not truncate the packet.

REQ-017 Counter behaviour:
- drop_count and ovr_count hold at 0xFFFF.
- pkt_count wraps 0xFFFFFFFF -> 0.
- Simultaneous increment events on one counter within a cycle cannot occur by construction.

REQ-018 busy = (state != IDLE) | m_valid.

Reset
REQ-019 While app_rst_n=0, the following SHALL all be 0 and the state SHALL be IDLE:
- m_data, m_valid, m_sof, m_eof, m_err, m_srcip, m_srcport;
- rx_ack, rx_rst, busy;
- all counters, the length counter and the recovery timer.

REQ-020 Reset asserted mid-packet SHALL abandon the packet without a terminator beat. Operation resumes on the first app_clk edge after app_rst_n rises.

Verification
REQ-021 Pass-through: 4-byte packet 0xA1..0xA4, rx_srcip=0x0A000001, rx_srcport=0x1234, m_ready=1 -> four beats on consecutive cycles, each 1 cycle after its ack; sof on 0xA1; eof on 0xA4 with err=0; pkt_count=1.

REQ-022 Backpressure: m_ready=0 for 5 cycles mid-packet -> rx_ack=0, m_data held stable, no bytes lost or duplicated.

REQ-023 Overlength: MAX_LEN=8, 12-byte packet -> 8 beats, the 8th with eof=1 and err=1; remaining 4 bytes acked with no output; drop_count=1; pkt_count unchanged.

REQ-024 Overrun mid-packet: rx_overrun rises after byte 3 -> terminator beat 0x00 with eof=1 and err=1; rx_rst high for exactly 4 cycles; IDLE after rx_overrun falls; ovr_count=1; drop_count=1.

REQ-025 Disabled: enable=0 with a 6-byte packet -> 6 acks, m_valid stays 0, drop_count=1; re-enable, and the next packet is delivered intact.

REQ-026 Async reset during DATA with m_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gbe_rx_app_ctrl.sv
// Application-side receive controller: pops bytes from the gbe_rx FIFO, frames them into
// a valid/ready stream, and handles disable, overlength and overrun recovery.
module gbe_rx_app_ctrl #(
    parameter int unsigned MAX_LEN        = 1472,
    parameter int unsigned OVR_RST_CYCLES = 4
) (
    input  logic        app_clk,
    input  logic        app_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_dvld,
    input  logic        rx_eof,
    input  logic        rx_badframe,
    input  logic [31:0] rx_srcip,
    input  logic [15:0] rx_srcport,
    input  logic        rx_overrun,
    output logic        rx_ack,
    output logic        rx_rst,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eof,
    output logic        m_err,
    output logic [31:0] m_srcip,
    output logic [15:0] m_srcport,
    input  logic        enable,
    output logic        busy,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic [15:0] ovr_count
);

    typedef enum logic [2:0] {StIdle, StData, StTerm, StDrop, StRecover} state_e;

    localparam logic [10:0] LastIdx   = 11'(MAX_LEN - 1);
    localparam logic [3:0]  RstCycles = 4'(OVR_RST_CYCLES);

    state_e      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic        sof_q, sof_d;
    logic        drop_idle_q, drop_idle_d;
    logic [3:0]  timer_q, timer_d;

    logic       out_free, load, capture;
    logic [7:0] ld_data;
    logic       ld_sof, ld_eof, ld_err;
    logic       inc_pkt, inc_drop, inc_ovr;

    // Output register can take a new beat when empty or being drained this cycle.
    assign out_free = ~m_valid | m_ready;
    assign rx_rst   = (state_q == StRecover) && (timer_q != 4'd0);
    assign busy     = (state_q != StIdle) | m_valid;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sof_d       = sof_q;
        drop_idle_d = drop_idle_q;
        timer_d     = timer_q;
        rx_ack      = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        ld_data     = rx_data;
        ld_sof      = 1'b0;
        ld_eof      = 1'b0;
        ld_err      = 1'b0;
        inc_pkt     = 1'b0;
        inc_drop    = 1'b0;
        inc_ovr     = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_overrun) begin
                    state_d = StRecover;
                end else if (rx_dvld && out_free) begin
                    if (enable) begin
                        state_d = StData;
                        capture = 1'b1;
                        len_d   = 11'd0;
                        sof_d   = 1'b1;
                    end else begin
                        state_d     = StDrop;
                        drop_idle_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (rx_overrun) begin
                    state_d = StTerm;
                end else if (rx_dvld && out_free) begin
                    rx_ack = 1'b1;
                    load   = 1'b1;
                    ld_sof = sof_q;
                    ld_eof = rx_eof;
                    ld_err = rx_eof & rx_badframe;
                    sof_d  = 1'b0;
                    len_d  = len_q + 11'd1;
                    if (rx_eof) begin
                        state_d  = StIdle;
                        inc_pkt  = ~rx_badframe;
                        inc_drop = rx_badframe;
                    end else if (len_q == LastIdx) begin
                        // Truncate: close the packet here, swallow the rest silently.
                        ld_eof      = 1'b1;
                        ld_err      = 1'b1;
                        inc_drop    = 1'b1;
                        state_d     = StDrop;
                        drop_idle_d = 1'b0;
                    end
                end
            end
            StTerm: begin
                if (out_free) begin
                    load     = 1'b1;
                    ld_data  = 8'h00;
                    ld_eof   = 1'b1;
                    ld_err   = 1'b1;
                    inc_drop = 1'b1;
                    state_d  = StRecover;
                end
            end
            StDrop: begin
                rx_ack = rx_dvld;
                if (rx_dvld && rx_eof) begin
                    state_d  = StIdle;
                    inc_drop = drop_idle_q;
                end else if (rx_overrun) begin
                    state_d = StRecover;
                end
            end
            StRecover: begin
                if (timer_q != 4'd0) begin
                    timer_d = timer_q - 4'd1;
                end else if (!rx_overrun && !m_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StRecover && state_q != StRecover) begin
            timer_d = RstCycles;
            inc_ovr = 1'b1;
        end
    end

    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            state_q     <= StIdle;
            len_q       <= 11'd0;
            sof_q       <= 1'b0;
            drop_idle_q <= 1'b0;
            timer_q     <= 4'd0;
            m_data      <= 8'h00;
            m_valid     <= 1'b0;
            m_sof       <= 1'b0;
            m_eof       <= 1'b0;
            m_err       <= 1'b0;
            m_srcip     <= 32'h0;
            m_srcport   <= 16'h0;
            pkt_count   <= 32'h0;
            drop_count  <= 16'h0;
            ovr_count   <= 16'h0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sof_q       <= sof_d;
            drop_idle_q <= drop_idle_d;
            timer_q     <= timer_d;
            if (load) begin
                m_data  <= ld_data;
                m_sof   <= ld_sof;
                m_eof   <= ld_eof;
                m_err   <= ld_err;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (capture) begin
                m_srcip   <= rx_srcip;
                m_srcport <= rx_srcport;
            end
            if (inc_pkt) pkt_count <= pkt_count + 32'd1;
            if (inc_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (inc_ovr && ovr_count != 16'hFFFF) ovr_count <= ovr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_gbe_rx_app_ctrl.sv
// Scoreboard bench for gbe_rx_app_ctrl: packet-level reference model feeds an expected-beat
// queue; an independent monitor checks every accepted output beat.
module tb_gbe_rx_app_ctrl;

    localparam int unsigned MaxLen = 8;
    localparam int unsigned RstCyc = 4;

    logic        app_clk = 1'b0;
    logic        app_rst_n = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_dvld, rx_eof, rx_badframe;
    logic [31:0] rx_srcip;
    logic [15:0] rx_srcport;
    logic        rx_overrun = 1'b0;
    logic        rx_ack, rx_rst;
    logic [7:0]  m_data;
    logic        m_valid, m_sof, m_eof, m_err;
    logic        m_ready = 1'b1;
    logic [31:0] m_srcip;
    logic [15:0] m_srcport;
    logic        enable;
    logic        busy;
    logic [31:0] pkt_count;
    logic [15:0] drop_count, ovr_count;

    gbe_rx_app_ctrl #(.MAX_LEN(MaxLen), .OVR_RST_CYCLES(RstCyc)) dut (
        .app_clk(app_clk), .app_rst_n(app_rst_n),
        .rx_data(rx_data), .rx_dvld(rx_dvld), .rx_eof(rx_eof), .rx_badframe(rx_badframe),
        .rx_srcip(rx_srcip), .rx_srcport(rx_srcport), .rx_overrun(rx_overrun),
        .rx_ack(rx_ack), .rx_rst(rx_rst),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eof(m_eof),
        .m_err(m_err), .m_srcip(m_srcip), .m_srcport(m_srcport),
        .enable(enable), .busy(busy),
        .pkt_count(pkt_count), .drop_count(drop_count), .ovr_count(ovr_count)
    );

    initial forever #5 app_clk = ~app_clk;

    typedef struct {
        logic [7:0]  data;
        logic        eof, bad, first, en;
        logic [31:0] ip;
        logic [15:0] port;
    } up_t;

    typedef struct {
        logic [7:0]  data;
        logic        sof, eof, err;
        logic [31:0] ip;
        logic [15:0] port;
    } beat_t;

    up_t   up_q[$];
    beat_t exp_q[$];

    int checks = 0, errors = 0;
    int exp_pkt = 0, exp_drop = 0, exp_ovr = 0;
    int rst_hi = 0, beats_seen = 0, pops = 0, ovr_at = 0, force_stall = 0;
    bit in_rst = 1'b1, lat_chk = 1'b0, stall_chk = 1'b0, rdy_rand = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Reference model: a packet either streams (truncated to MaxLen) or vanishes.
    function automatic void push_pkt(input int len, input bit bad, input bit en, input bit seq,
                                     input logic [7:0] base, input logic [31:0] ip,
                                     input logic [15:0] port);
        logic [7:0] bytes[$];
        int n;
        for (int i = 0; i < len; i++) begin
            bytes.push_back(seq ? 8'(base + 8'(i)) : 8'($urandom));
            up_q.push_back(up_t'{bytes[i], i == len - 1, bad, i == 0, en, ip, port});
        end
        if (!en) begin
            exp_drop++;
        end else begin
            n = (len > int'(MaxLen)) ? int'(MaxLen) : len;
            for (int i = 0; i < n; i++)
                exp_q.push_back(beat_t'{bytes[i], i == 0, i == n - 1,
                                        (i == n - 1) && (bad || len > int'(MaxLen)), ip, port});
            if (len <= int'(MaxLen) && !bad) exp_pkt++;
            else exp_drop++;
        end
    endfunction

    function automatic void push_rand();
        push_pkt($urandom_range(1, 12), $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                 1'b0, 8'h00, $urandom, 16'($urandom));
    endfunction

    function automatic void drive_inputs();
        if (up_q.size() > 0) begin
            rx_dvld     = 1'b1;
            rx_data     = up_q[0].data;
            rx_eof      = up_q[0].eof;
            rx_badframe = up_q[0].bad;
            rx_srcip    = up_q[0].ip;
            rx_srcport  = up_q[0].port;
            // enable only matters at packet start; scramble it elsewhere
            enable      = up_q[0].first ? up_q[0].en : 1'($urandom_range(0, 1));
        end else begin
            rx_dvld     = 1'b0;
            rx_data     = 8'($urandom);
            rx_eof      = 1'b0;
            rx_badframe = 1'b0;
            rx_srcip    = $urandom;
            rx_srcport  = 16'($urandom);
            enable      = 1'($urandom_range(0, 1));
        end
    endfunction

    // Upstream FIFO and downstream sink
    initial begin
        logic ack_s, rst_s;
        up_t  tmp;
        drive_inputs();
        forever begin
            @(negedge app_clk);
            ack_s = rx_ack;
            rst_s = rx_rst;
            @(posedge app_clk);
            #1;
            if (ack_s && up_q.size() > 0) begin
                tmp = up_q.pop_front();
                pops++;
                if (ovr_at != 0 && pops == ovr_at) begin
                    rx_overrun = 1'b1;
                    ovr_at = 0;
                end
            end
            if (rst_s) begin
                up_q.delete();
                rx_overrun = 1'b0;
            end
            if (force_stall > 0) begin
                m_ready = 1'b0;
                force_stall--;
            end else begin
                m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            drive_inputs();
        end
    end

    // Monitor
    initial begin
        beat_t cur, held, e;
        bit prev_stall = 1'b0, prev_ack = 1'b0;
        forever begin
            @(negedge app_clk);
            if (in_rst || !app_rst_n) begin
                prev_stall = 1'b0;
                prev_ack   = 1'b0;
            end else begin
                cur = beat_t'{m_data, m_sof, m_eof, m_err, m_srcip, m_srcport};
                if (prev_stall)
                    chk("hold", {m_valid, m_data, m_sof, m_eof, m_err, m_srcip, m_srcport},
                        {1'b1, held.data, held.sof, held.eof, held.err, held.ip, held.port});
                if (lat_chk && prev_ack) chk("ack_latency", 64'(m_valid), 64'd1);
                if (stall_chk && m_valid && !m_ready) chk("stall_no_ack", 64'(rx_ack), 64'd0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat actual=%h required=none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {m_data, m_sof, m_eof, m_err, m_srcip, m_srcport},
                            {e.data, e.sof, e.eof, e.err, e.ip, e.port});
                        beats_seen++;
                    end
                end
                if (rx_rst) rst_hi++;
                prev_stall = m_valid && !m_ready;
                held       = cur;
                prev_ack   = rx_ack;
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge app_clk);
            if (up_q.size() == 0 && exp_q.size() == 0 && !busy && !rx_overrun) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain actual=up%0d/exp%0d/busy%0d required=idle", name,
                     up_q.size(), exp_q.size(), busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_out"}, {m_data, m_valid, m_sof, m_eof, m_err, m_srcip, m_srcport,
                             rx_ack, rx_rst, busy}, 64'd0);
        chk({name, "_cnt"}, {pkt_count, drop_count, ovr_count}, 64'd0);
    endtask

    initial begin
        int b0, r0;
        bit seen;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge app_clk);
        #2;
        app_rst_n = 1'b1;
        in_rst    = 1'b0;

        // Plain 4-byte pass-through
        lat_chk = 1'b1;
        push_pkt(4, 1'b0, 1'b1, 1'b1, 8'hA1, 32'h0A00_0001, 16'h1234);
        wait_idle("pass", 200);
        lat_chk = 1'b0;
        chk("pkt_count_pass", 64'(pkt_count), 64'd1);

        // Five-cycle stall mid-packet
        stall_chk = 1'b1;
        b0 = beats_seen;
        push_pkt(8, 1'b0, 1'b1, 1'b1, 8'h10, $urandom, 16'($urandom));
        for (int n = 0; n < 200 && beats_seen < b0 + 2; n++) @(negedge app_clk);
        force_stall = 5;
        wait_idle("stall", 200);
        stall_chk = 1'b0;

        // Overlength 12 bytes against MaxLen 8
        push_pkt(12, 1'b0, 1'b1, 1'b1, 8'h40, $urandom, 16'($urandom));
        wait_idle("ovlen", 200);
        chk("drop_ovlen", 64'(drop_count), 64'(exp_drop));
        chk("pkt_ovlen", 64'(pkt_count), 64'(exp_pkt));

        // Overrun after the third byte: three beats, then the terminator
        begin
            logic [31:0] ip = $urandom;
            logic [15:0] pt = 16'($urandom);
            r0 = rst_hi;
            ovr_at = pops + 3;
            for (int i = 0; i < 6; i++)
                up_q.push_back(up_t'{8'(8'h60 + 8'(i)), i == 5, 1'b0, i == 0, 1'b1, ip, pt});
            for (int i = 0; i < 3; i++)
                exp_q.push_back(beat_t'{8'(8'h60 + 8'(i)), i == 0, 1'b0, 1'b0, ip, pt});
            exp_q.push_back(beat_t'{8'h00, 1'b0, 1'b1, 1'b1, ip, pt});
            exp_drop++;
            exp_ovr++;
        end
        wait_idle("ovr", 300);
        chk("rx_rst_cycles", 64'(rst_hi - r0), 64'(RstCyc));
        chk("ovr_count", 64'(ovr_count), 64'(exp_ovr));
        chk("drop_ovr", 64'(drop_count), 64'(exp_drop));

        // Disabled packet is swallowed, the next enabled one goes through
        push_pkt(6, 1'b0, 1'b0, 1'b1, 8'h80, $urandom, 16'($urandom));
        push_pkt(5, 1'b0, 1'b1, 1'b1, 8'h90, $urandom, 16'($urandom));
        wait_idle("disabled", 300);
        chk("drop_disabled", 64'(drop_count), 64'(exp_drop));
        chk("pkt_disabled", 64'(pkt_count), 64'(exp_pkt));

        // Random traffic with random backpressure
        rdy_rand = 1'b1;
        repeat (40) push_rand();
        wait_idle("random", 5000);
        chk("pkt_random", 64'(pkt_count), 64'(exp_pkt));
        chk("drop_random", 64'(drop_count), 64'(exp_drop));

        // Asynchronous reset while a beat is held
        rdy_rand    = 1'b0;
        force_stall = 1000;
        push_pkt(6, 1'b0, 1'b1, 1'b1, 8'hC0, $urandom, 16'($urandom));
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge app_clk);
            seen = m_valid;
        end
        chk("async_pre_valid", 64'(seen), 64'd1);
        #2;
        in_rst    = 1'b1;
        app_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        up_q.delete();
        exp_q.delete();
        exp_pkt     = 0;
        exp_drop    = 0;
        exp_ovr     = 0;
        force_stall = 0;
        repeat (2) @(posedge app_clk);
        #2;
        app_rst_n = 1'b1;
        in_rst    = 1'b0;

        rdy_rand = 1'b1;
        repeat (15) push_rand();
        wait_idle("post_reset", 3000);
        chk("pkt_final", 64'(pkt_count), 64'(exp_pkt));
        chk("drop_final", 64'(drop_count), 64'(exp_drop));
        chk("ovr_final", 64'(ovr_count), 64'(exp_ovr));
        chk("busy_final", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
